// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and fills the IF/ID register.
// Latency: the ROM answers in the same cycle, so a fetched word lands in IF/ID on the next edge.
// Backpressure: stall_i freezes the PC and IF/ID. Flush and redirect insert one bubble.
module fetch_stage #(
    parameter int unsigned               ADDRESS_WIDTH = 16,
    parameter int unsigned               DATA_WIDTH    = 32,
    parameter logic [31:0]               RESET_PC      = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    output logic [ADDRESS_WIDTH-1:0]     imem_addr_o,
    input  logic [DATA_WIDTH-1:0]        imem_rd_i,
    output logic                         if_id_valid_o,
    output logic [DATA_WIDTH-1:0]        if_id_instr_o,
    output logic [31:0]                  if_id_pc_o,
    output logic [31:0]                  if_id_pc_plus4_o,
    output logic                         fetch_fault_o,
    output logic [31:0]                  fault_pc_o
);

    // BOOT gives one settle cycle after reset, RUN fetches, FAULT waits for a good redirect.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                  state_q,        state_d;
    logic [31:0]             pc_q,           pc_d;
    logic                    valid_q,        valid_d;
    logic [DATA_WIDTH-1:0]   instr_q,        instr_d;
    logic [31:0]             id_pc_q,        id_pc_d;
    logic [31:0]             id_pc_plus4_q,  id_pc_plus4_d;
    logic                    fault_q,        fault_d;
    logic [31:0]             fault_pc_q,     fault_pc_d;

    logic [31:0]             pc_plus4;
    logic                    target_aligned;

    // Sequential PC increment wraps naturally at 2^32.
    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = (redirect_pc_i[1:0] == 2'b00);

    // ROM index is a plain slice of the PC, so upper PC bits alias (index wraps).
    assign imem_addr_o    = pc_q[ADDRESS_WIDTH+1:2];

    // Next-state logic: redirect beats flush beats stall beats advance while running.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;

        unique case (state_q)
            ST_BOOT: begin
                // IF/ID is already invalid from reset; only move on.
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (redirect_i) begin
                    // Either way the word currently being fetched is on the wrong path.
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (target_aligned) begin
                        pc_d = redirect_pc_i;
                    end else begin
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc_i;
                        state_d    = ST_FAULT;
                    end
                end else if (flush_i) begin
                    // PC is not advanced, so the same word is fetched again next cycle.
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (stall_i) begin
                    // Hold everything exactly as it is.
                    pc_d = pc_q;
                end else begin
                    valid_d       = 1'b1;
                    instr_d       = imem_rd_i;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_plus4;
                    pc_d          = pc_plus4;
                end
            end

            ST_FAULT: begin
                // Nothing is fetched while faulted; stall and flush have no meaning here.
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                if (redirect_i) begin
                    if (target_aligned) begin
                        fault_d = 1'b0;
                        pc_d    = redirect_pc_i;
                        state_d = ST_RUN;
                    end else begin
                        // Record the most recent bad target; stay faulted.
                        fault_pc_d = redirect_pc_i;
                    end
                end
            end

            default: begin
                state_d = ST_BOOT;
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        endcase
    end

    // State, PC and IF/ID registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            valid_q       <= 1'b0;
            instr_q       <= NOP_INSTR;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd4;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    // IF/ID outputs come straight from registers; instr_q already holds NOP when invalid.
    assign if_id_valid_o    = valid_q;
    assign if_id_instr_o    = instr_q;
    assign if_id_pc_o       = id_pc_q;
    assign if_id_pc_plus4_o = id_pc_plus4_q;
    assign fetch_fault_o    = fault_q;
    assign fault_pc_o       = fault_pc_q;

endmodule
